// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM: sequences ALU, IR, PC and memory port.
// Optional ILLEGAL_TRAP_EN adds a sticky TRAP state for unknown opcodes.
module multicycle_controller #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       Op,
  input  logic             Zero,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             AdrSrc,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic             RegWrite,
  output logic [CNT_W-1:0] instret,
  output logic             illegal
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

`ifdef ILLEGAL_TRAP_EN
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10,
    S_TRAP     = 4'd11
  } state_e;
`else
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10
  } state_e;
`endif

  state_e           state_q, state_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             retire;
  logic             pc_update;
  logic             branch;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_FETCH;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        unique case (Op)
          OP_LOAD,
          OP_STORE: state_d = S_MEMADR;
          OP_RTYPE: state_d = S_EXECR;
          OP_ITYPE: state_d = S_EXECI;
          OP_JAL:   state_d = S_JAL;
          OP_BEQ:   state_d = S_BEQ;
`ifdef ILLEGAL_TRAP_EN
          default:  state_d = S_TRAP;
`else
          default:  state_d = S_FETCH;
`endif
        endcase
      end
      S_MEMADR: begin
        state_d = (Op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_MEMWRITE: begin
        if (mem_ready) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_EXECR: state_d = S_ALUWB;
      S_EXECI: state_d = S_ALUWB;
      S_ALUWB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_JAL:   state_d = S_ALUWB;
      S_BEQ: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
`ifdef ILLEGAL_TRAP_EN
      S_TRAP:  state_d = S_TRAP;
`endif
      default: state_d = S_FETCH;
    endcase
  end

  always_comb begin
    instret_d = instret_q + {{(CNT_W-1){1'b0}}, retire};
  end

  always_comb begin
    pc_update = 1'b0;
    branch    = 1'b0;
    AdrSrc    = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ALUOp     = 2'b00;
    RegWrite  = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = mem_ready;
        pc_update = mem_ready;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD: AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b10;
      end
      S_EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b10;
      end
      S_ALUWB: RegWrite = 1'b1;
      S_JAL: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        pc_update = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b01;
        branch  = 1'b1;
      end
      default: ;
    endcase
  end

  assign PCWrite = pc_update | (branch & Zero);
  assign instret = instret_q;

`ifdef ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;

  always_comb begin
    illegal_d = illegal_q | (state_d == S_TRAP);
  end

  always_ff @(posedge clk) begin
    if (!rst) illegal_q <= 1'b0;
    else      illegal_q <= illegal_d;
  end

  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed table-driven bench for multicycle_controller.
// Follows ILLEGAL_TRAP_EN the same way the design does.
module tb_multicycle_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  Op;
  logic        Zero;
  logic        mem_ready;
  logic        PCWrite;
  logic        AdrSrc;
  logic        MemWrite;
  logic        IRWrite;
  logic [1:0]  ResultSrc;
  logic [1:0]  ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [1:0]  ALUOp;
  logic        RegWrite;
  logic [31:0] instret;
  logic        illegal;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  multicycle_controller #(.CNT_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .Op        (Op),
    .Zero      (Zero),
    .mem_ready (mem_ready),
    .PCWrite   (PCWrite),
    .AdrSrc    (AdrSrc),
    .MemWrite  (MemWrite),
    .IRWrite   (IRWrite),
    .ResultSrc (ResultSrc),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ALUOp     (ALUOp),
    .RegWrite  (RegWrite),
    .instret   (instret),
    .illegal   (illegal)
  );

  typedef struct {
    logic [6:0]  op;
    logic        zero;
    logic        rdy;
    logic [13:0] ctl;
    logic [31:0] ir;
  } vec_t;

  vec_t tbl[$];

  localparam logic [6:0] R  = 7'b0110011;
  localparam logic [6:0] I  = 7'b0010011;
  localparam logic [6:0] LD = 7'b0000011;
  localparam logic [6:0] ST = 7'b0100011;
  localparam logic [6:0] BR = 7'b1100011;
  localparam logic [6:0] JL = 7'b1101111;
  localparam logic [6:0] IL = 7'b1111111;

  // {PCWrite,AdrSrc,MemWrite,IRWrite,ResultSrc,ALUSrcA,ALUSrcB,ALUOp,RegWrite}
  function automatic logic [13:0] cw(
    input logic pcw, input logic adr,
    input logic mw, input logic irw,
    input logic [1:0] rs, input logic [1:0] sa,
    input logic [1:0] sb, input logic [1:0] aop,
    input logic rw);
    return {pcw, adr, mw, irw, rs, sa, sb, aop, rw};
  endfunction

  logic [13:0] F1, F0, DEC, MADR, MRD, MWB, MWR;
  logic [13:0] EXR, EXI, AWB, JAL, BEQ1, BEQ0, NONE;

  task automatic add(input logic [6:0] op, input logic z,
                     input logic r, input logic [13:0] c,
                     input logic [31:0] i);
    vec_t v;
    v.op = op; v.zero = z; v.rdy = r; v.ctl = c; v.ir = i;
    tbl.push_back(v);
  endtask

  task automatic check(input int id, input logic [13:0] ec,
                       input logic [31:0] ei, input logic eill);
    logic [13:0] got;
    got = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ALUOp, RegWrite};
    total++;
    if (got !== ec) begin
      bad++;
      $display("FAIL ctl[%0d] got=%b want=%b", id, got, ec);
    end
    total++;
    if (instret !== ei) begin
      bad++;
      $display("FAIL instret[%0d] got=%0d want=%0d", id, instret, ei);
    end
    total++;
    if (illegal !== eill) begin
      bad++;
      $display("FAIL illegal[%0d] got=%b want=%b", id, illegal, eill);
    end
  endtask

  task automatic step(input logic r, input logic [6:0] op,
                      input logic z, input logic rdy,
                      input logic [13:0] ec, input logic [31:0] ei,
                      input logic eill, input int id);
    rst = r; Op = op; Zero = z; mem_ready = rdy;
    #1;
    check(id, ec, ei, eill);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] base;
    F1   = cw(1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 2'b00, 0);
    F0   = cw(0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 0);
    DEC  = cw(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 0);
    MADR = cw(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 0);
    MRD  = cw(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0);
    MWB  = cw(0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 1);
    MWR  = cw(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0);
    EXR  = cw(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 0);
    EXI  = cw(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b10, 0);
    AWB  = cw(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1);
    JAL  = cw(1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00, 0);
    BEQ1 = cw(1, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b01, 0);
    BEQ0 = cw(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b01, 0);
    NONE = '0;

    add(R,  0, 0, F0,   0);
    add(R,  0, 1, F1,   0);
    add(R,  1, 0, DEC,  0);
    add(R,  1, 0, EXR,  0);
    add(R,  1, 0, AWB,  0);
    add(I,  0, 1, F1,   1);
    add(I,  0, 1, DEC,  1);
    add(I,  1, 1, EXI,  1);
    add(I,  0, 1, AWB,  1);
    add(LD, 0, 1, F1,   2);
    add(LD, 0, 0, DEC,  2);
    add(LD, 0, 0, MADR, 2);
    add(LD, 0, 0, MRD,  2);
    add(LD, 0, 0, MRD,  2);
    add(LD, 1, 1, MRD,  2);
    add(LD, 0, 0, MWB,  2);
    add(ST, 0, 0, F0,   3);
    add(ST, 0, 1, F1,   3);
    add(ST, 0, 1, DEC,  3);
    add(ST, 0, 1, MADR, 3);
    add(ST, 1, 0, MWR,  3);
    add(ST, 0, 1, MWR,  3);
    add(BR, 0, 1, F1,   4);
    add(BR, 1, 1, DEC,  4);
    add(BR, 1, 0, BEQ1, 4);
    add(BR, 0, 1, F1,   5);
    add(BR, 0, 1, DEC,  5);
    add(BR, 0, 1, BEQ0, 5);
    add(JL, 0, 1, F1,   6);
    add(JL, 1, 1, DEC,  6);
    add(JL, 1, 0, JAL,  6);
    add(JL, 1, 0, AWB,  6);
    add(JL, 0, 0, F0,   7);

    rst = 1'b0; Op = R; Zero = 1'b0; mem_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    step(0, R, 0, 0, F0, 0, 0, 100);

    foreach (tbl[k]) begin
      step(1, tbl[k].op, tbl[k].zero, tbl[k].rdy,
           tbl[k].ctl, tbl[k].ir, 0, k);
    end

    step(1, IL, 0, 1, F1,  7, 0, 200);
    step(1, IL, 0, 1, DEC, 7, 0, 201);
`ifdef ILLEGAL_TRAP_EN
    for (int n = 0; n < 3; n++) begin
      step(1, IL, 1, 1, NONE, 7, 1, 202 + n);
    end
    step(0, IL, 1, 1, NONE, 7, 1, 205);
    base = 0;
`else
    step(1, IL, 1, 0, F0, 7, 0, 202);
    base = 7;
`endif

    step(1, ST, 0, 1, F1,   base, 0, 300);
    step(1, ST, 0, 1, DEC,  base, 0, 301);
    step(1, ST, 0, 1, MADR, base, 0, 302);
    step(1, ST, 0, 0, MWR,  base, 0, 303);
    step(0, ST, 0, 1, MWR,  base, 0, 304);
    step(1, ST, 0, 0, F0,   0,    0, 305);
    step(1, ST, 0, 0, F0,   0,    0, 306);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
